// File: rtl/fft_out_reorder_if.sv
// Handshake bundle between the last FFT stage, the reorder buffer
// and the downstream serial consumer.
interface fft_out_reorder_if #(
    parameter int NBITS = 10,
    parameter int N     = 128
);
    localparam int DW    = 2 * (NBITS + 1);
    localparam int LOG2N = $clog2(N);

    logic               in_valid;
    logic               in_ready;
    logic [2*DW-1:0]    in0_up;
    logic [2*DW-1:0]    in0_down;
    logic [2*DW-1:0]    in1_up;
    logic [2*DW-1:0]    in1_down;
    logic               out_valid;
    logic               out_ready;
    logic [2*DW-1:0]    out_data;
    logic [LOG2N-1:0]   out_index;
    logic               out_last;

    modport master (
        output in_valid, in0_up, in0_down, in1_up, in1_down, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in0_up, in0_down, in1_up, in1_down, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: 4-lane bit-reversed beats in,
// one natural-order complex sample per cycle out.
module fft_out_reorder #(
    parameter int NBITS = 10,
    parameter int N     = 128
) (
    input  logic clk,
    input  logic rst,
    fft_out_reorder_if.slave bus
);
    localparam int DW    = 2 * (NBITS + 1);
    localparam int W     = 2 * DW;
    localparam int LOG2N = $clog2(N);
    localparam int KW    = LOG2N - 2;
    localparam logic [KW-1:0]    KLAST = KW'(N / 4 - 1);
    localparam logic [LOG2N-1:0] RLAST = LOG2N'(N - 1);

    logic [W-1:0]     mem0 [N];
    logic [W-1:0]     mem1 [N];
    logic             wbank;
    logic             rbank;
    logic [1:0]       full;
    logic [KW-1:0]    k;
    logic [LOG2N-1:0] raddr;
    logic [W-1:0]     rdata;
    logic             in_fire;
    logic             out_fire;
    logic [LOG2N-1:0] a0, a1, a2, a3;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    assign a0 = bitrev({k, 2'd0});
    assign a1 = bitrev({k, 2'd1});
    assign a2 = bitrev({k, 2'd2});
    assign a3 = bitrev({k, 2'd3});

    assign bus.in_ready  = !full[wbank];
    assign bus.out_valid = full[rbank];
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;

    assign rdata         = rbank ? mem1[raddr] : mem0[raddr];
    assign bus.out_data  = bus.out_valid ? rdata : '0;
    assign bus.out_index = raddr;
    assign bus.out_last  = bus.out_valid & (raddr == RLAST);

    // Scatter one beat into the write bank at its bit-reversed bins
    always_ff @(posedge clk) begin
        if (in_fire && !wbank) begin
            mem0[a0] <= bus.in0_up;
            mem0[a1] <= bus.in0_down;
            mem0[a2] <= bus.in1_up;
            mem0[a3] <= bus.in1_down;
        end
        if (in_fire && wbank) begin
            mem1[a0] <= bus.in0_up;
            mem1[a1] <= bus.in0_down;
            mem1[a2] <= bus.in1_up;
            mem1[a3] <= bus.in1_down;
        end
    end

    // Bank pointers, beat counter, read address and full flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbank <= 1'b0;
            rbank <= 1'b0;
            full  <= 2'b00;
            k     <= '0;
            raddr <= '0;
        end else begin
            if (in_fire) begin
                if (k == KLAST) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                    k           <= '0;
                end else begin
                    k <= k + 1'b1;
                end
            end
            if (out_fire) begin
                if (raddr == RLAST) begin
                    full[rbank] <= 1'b0;
                    rbank       <= ~rbank;
                    raddr       <= '0;
                end else begin
                    raddr <= raddr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for the FFT output reorder buffer (N=128, NBITS=10).
// Lane i of frame f carries re = i + 256*f, im = -i.
module tb_fft_out_reorder;
    localparam int NBITS = 10;
    localparam int N     = 128;
    localparam int DW    = 2 * (NBITS + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    fft_out_reorder_if #(.NBITS(NBITS), .N(N)) bus ();

    fft_out_reorder #(.NBITS(NBITS), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rev7(input int v);
        int r = 0;
        int x = v;
        repeat (7) begin
            r = (r << 1) | (x & 1);
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic logic [2*DW-1:0] lane(input int f, input int i);
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        re = DW'(i + 256 * f);
        im = DW'(-i);
        return {re, im};
    endfunction

    task automatic send_beats(input int f, input int k0, input int k1,
                              input bit tog, output int stall0);
        int cnt;
        stall0 = 0;
        for (int k = k0; k < k1; k++) begin
            if (tog) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in0_up   = lane(f, 4 * k);
            bus.in0_down = lane(f, 4 * k + 1);
            bus.in1_up   = lane(f, 4 * k + 2);
            bus.in1_down = lane(f, 4 * k + 3);
            bus.in_valid = 1'b1;
            cnt = 0;
            @(negedge clk);
            while (!bus.in_ready && cnt < 2000) begin
                cnt++;
                @(negedge clk);
            end
            if (k == k0) stall0 = cnt;
            if (!bus.in_ready) begin
                check("in_timeout", 64'd0, 64'd1);
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int f0, input int nsamp, input bit rnd);
        int got = 0;
        int cyc = 0;
        int f;
        int b;
        bit stalled = 0;
        logic [2*DW-1:0] hold_d = '0;
        logic [6:0]      hold_i = '0;
        while (got < nsamp && cyc < 20000) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!rnd && got > 0) check("gap", 64'(bus.out_valid), 64'd1);
            if (bus.out_valid) begin
                if (stalled) begin
                    check("stall_data", 64'(bus.out_data), 64'(hold_d));
                    check("stall_idx", 64'(bus.out_index), 64'(hold_i));
                end
                if (bus.out_ready) begin
                    f = f0 + got / 128;
                    b = got % 128;
                    check("idx", 64'(bus.out_index), 64'(b));
                    check("data", 64'(bus.out_data), 64'(lane(f, rev7(b))));
                    check("last", 64'(bus.out_last), 64'(b == 127));
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = bus.out_data;
                    hold_i  = bus.out_index;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got < nsamp) check("drain_timeout", 64'(got), 64'(nsamp));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int s;
        int s3;
        int s4;
        int cnt;
        bus.in_valid  = 1'b0;
        bus.in0_up    = '0;
        bus.in0_down  = '0;
        bus.in1_up    = '0;
        bus.in1_down  = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_index", 64'(bus.out_index), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // single frame, consumer always ready
        fork
            send_beats(0, 0, 32, 1'b0, s);
            drain(0, 128, 1'b0);
        join

        // toggling in_valid, frame completes on the 32nd accepted beat
        send_beats(1, 0, 31, 1'b1, s);
        @(negedge clk);
        check("tog_not_full", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        send_beats(1, 31, 32, 1'b1, s);
        @(negedge clk);
        check("tog_full", 64'(bus.out_valid), 64'd1);
        check("tog_idx0", 64'(bus.out_index), 64'd0);
        check("tog_last0", 64'(bus.out_last), 64'd0);
        @(posedge clk); #1;
        drain(1, 128, 1'b1);

        // three frames back to back
        fork
            begin
                send_beats(2, 0, 32, 1'b0, s);
                send_beats(3, 0, 32, 1'b0, s3);
                send_beats(4, 0, 32, 1'b0, s4);
            end
            drain(2, 384, 1'b0);
        join
        check("b2b_stall_f3", 64'(s3), 64'd0);
        check("b2b_stall_f4", 64'(s4), 64'd96);

        // last read of one bank coincides with last write of the other
        send_beats(5, 0, 32, 1'b0, s);
        send_beats(6, 0, 31, 1'b0, s);
        fork
            drain(5, 256, 1'b0);
            begin
                cnt = 0;
                @(negedge clk);
                while (!(bus.out_valid && bus.out_index == 7'd126)
                       && cnt < 500) begin
                    cnt++;
                    @(negedge clk);
                end
                check("ovl_found", 64'(bus.out_index), 64'd126);
                @(posedge clk); #1;
                bus.in0_up   = lane(6, 124);
                bus.in0_down = lane(6, 125);
                bus.in1_up   = lane(6, 126);
                bus.in1_down = lane(6, 127);
                bus.in_valid = 1'b1;
                @(negedge clk);
                check("ovl_idx127", 64'(bus.out_index), 64'd127);
                check("ovl_rdy_pre", 64'(bus.in_ready), 64'd1);
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                @(negedge clk);
                check("ovl_valid", 64'(bus.out_valid), 64'd1);
                check("ovl_idx0", 64'(bus.out_index), 64'd0);
                check("ovl_rdy_post", 64'(bus.in_ready), 64'd1);
            end
        join

        // reset mid-operation
        send_beats(7, 0, 32, 1'b0, s);
        drain(7, 10, 1'b0);
        send_beats(8, 0, 10, 1'b0, s);
        check("pre_rst_idx", 64'(bus.out_index), 64'd10);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_out_data", 64'(bus.out_data), 64'd0);
        check("arst_out_index", 64'(bus.out_index), 64'd0);
        check("arst_out_last", 64'(bus.out_last), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        fork
            send_beats(9, 0, 32, 1'b0, s);
            drain(9, 128, 1'b0);
        join

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end
endmodule
